// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing definitions: vector type, binder shift table,
// decoder FSM states and the rotate helpers used by binders and unbinders.
package hdc_pkg;

  localparam int HV_DIM     = 64;
  localparam int NUM_SHIFTS = 16;

  typedef logic [HV_DIM-1:0] hv_t;

  // Positional shifts shared with the encoder binders; 0 and HV_DIM both mean identity.
  localparam int SHIFTS [NUM_SHIFTS] = '{5, 0, 3, 17, 64, 29, 11, 40, 7, 63, 22, 1, 33, 9, 50, 14};

  typedef enum logic [2:0] {
    IDLE,
    UNBIND,
    SCORE,
    EMIT,
    DONE
  } dec_state_e;

  function automatic hv_t hv_rotl(input hv_t x, input int unsigned sh);
    int unsigned s;
    s = sh % HV_DIM;
    return (x << s) | (x >> (HV_DIM - s));
  endfunction

  function automatic hv_t hv_rotr(input hv_t x, input int unsigned sh);
    int unsigned s;
    s = sh % HV_DIM;
    return (x >> s) | (x << (HV_DIM - s));
  endfunction

endpackage

// File: rtl/hv_popcount.sv
// Combinational population count over a W-bit vector, built as a balanced
// adder tree so similarity-search blocks can reuse it.
module hv_popcount #(
  parameter  int W  = 64,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] count
);

  localparam int LOG = (W > 1) ? $clog2(W) : 0;
  localparam int P   = 1 << LOG;

  // In-place pairwise reduction: each pass halves the number of live partial sums.
  function automatic logic [CW-1:0] tree_sum(input logic [W-1:0] v);
    logic [P-1:0]  padded;
    logic [CW-1:0] acc [P];
    padded = P'(v);
    for (int i = 0; i < P; i++) begin
      acc[i] = CW'(padded[i]);
    end
    for (int step = 1; step < P; step = step * 2) begin
      for (int i = 0; i + step < P; i = i + 2 * step) begin
        acc[i] = acc[i] + acc[i + step];
      end
    end
    return acc[0];
  endfunction

  assign count = tree_sum(vec);

endmodule

// File: rtl/dec_unbinder_pack.sv
// Decoder pack: per channel, rotate the bound query back by that channel's shift,
// score it against every level hypervector and emit the best-matching level.
module dec_unbinder_pack
  import hdc_pkg::*;
#(
  parameter  int NUM_CH     = 10,
  parameter  int BASE       = 0,
  parameter  int NUM_LEVELS = 10,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LV_W       = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int SC_W       = $clog2(HV_DIM + 1)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            start_decoding,
  input  hv_t             query_hv,
  input  hv_t             level_hv [NUM_LEVELS],
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_channel,
  output logic [LV_W-1:0] out_level,
  output logic [SC_W-1:0] out_score,
  output logic            done
);

  dec_state_e      state_q, state_d;
  hv_t             query_q, query_d;
  hv_t             unbound_q, unbound_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [LV_W-1:0] lvl_q, lvl_d;
  logic [LV_W-1:0] best_lvl_q, best_lvl_d;
  logic [SC_W-1:0] best_score_q, best_score_d;
  logic [SC_W-1:0] score;
  hv_t             level_sel;
  hv_t             masked;
  logic [31:0]     ch_shift [1 << CH_W];

  // Per-channel slice of the shared shift table, padded so any ch index is in range.
  for (genvar i = 0; i < (1 << CH_W); i++) begin : g_shift
    if (i < NUM_CH) begin : g_used
      assign ch_shift[i] = 32'(SHIFTS[BASE + i]);
    end else begin : g_unused
      assign ch_shift[i] = '0;
    end
  end

  assign level_sel = level_hv[lvl_q];
  assign masked    = unbound_q & level_sel;

  hv_popcount #(
    .W(HV_DIM)
  ) u_popcount (
    .vec  (masked),
    .count(score)
  );

  always_comb begin
    state_d      = state_q;
    query_d      = query_q;
    unbound_d    = unbound_q;
    ch_d         = ch_q;
    lvl_d        = lvl_q;
    best_lvl_d   = best_lvl_q;
    best_score_d = best_score_q;
    unique case (state_q)
      IDLE: begin
        if (start_decoding) begin
          query_d = query_hv;
          ch_d    = '0;
          state_d = UNBIND;
        end
      end
      UNBIND: begin
        unbound_d    = hv_rotr(query_q, ch_shift[ch_q]);
        lvl_d        = '0;
        best_lvl_d   = '0;
        best_score_d = '0;
        state_d      = SCORE;
      end
      SCORE: begin
        // Strict compare keeps the lowest index on ties; level 0 always seeds the best.
        if ((lvl_q == '0) || (score > best_score_q)) begin
          best_score_d = score;
          best_lvl_d   = lvl_q;
        end
        if (lvl_q == LV_W'(NUM_LEVELS - 1)) begin
          state_d = EMIT;
        end else begin
          lvl_d = lvl_q + LV_W'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            state_d = DONE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = UNBIND;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q      <= IDLE;
      query_q      <= '0;
      unbound_q    <= '0;
      ch_q         <= '0;
      lvl_q        <= '0;
      best_lvl_q   <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      query_q      <= query_d;
      unbound_q    <= unbound_d;
      ch_q         <= ch_d;
      lvl_q        <= lvl_d;
      best_lvl_q   <= best_lvl_d;
      best_score_q <= best_score_d;
    end
  end

  assign busy        = (state_q == UNBIND) || (state_q == SCORE) || (state_q == EMIT);
  assign out_valid   = (state_q == EMIT);
  assign done        = (state_q == DONE);
  assign out_channel = ch_q;
  assign out_level   = best_lvl_q;
  assign out_score   = best_score_q;

endmodule
